// File: rtl/muxn_rr.sv
// -----------------------------------------------------------------------------
// muxn_rr
//
// N-channel, W-bit registered multiplexer with a per-channel request/grant
// handshake and a valid/ready output stage. It merges several producer streams
// onto one downstream consumer. There are two ways to pick the source channel:
//   - manual  (mode = 0): the channel given by `sel`, if that channel requests.
//   - round-robin (mode = 1): the first requesting channel after the
//     last-granted one. The last-granted channel has the lowest priority.
//
// A grant is issued combinationally in the same cycle the output register
// loads. The granted beat appears on y / y_chan / y_valid one cycle later.
//
// Parameters
//   W     data width per channel
//   N     number of channels (N >= 2)
//   SELW  channel-index width (>= ceil(log2(N)))
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   din      in   channel data, channel i in din[i*W +: W]
//   req      in   per-channel request (data valid on din)
//   grant    out  one-hot, combinational: the beat of this channel is taken now
//   mode     in   0 = manual select, 1 = round-robin
//   sel      in   manual-mode channel index (values >= N select nothing)
//   y        out  registered output data
//   y_chan   out  channel index that produced y
//   y_valid  out  y / y_chan hold a valid beat
//   ready    in   downstream accepts the beat when y_valid && ready
// -----------------------------------------------------------------------------
module muxn_rr #(
   parameter int W    = 8,
   parameter int N    = 4,
   parameter int SELW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N*W-1:0]  din,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    grant,
   input  logic            mode,
   input  logic [SELW-1:0] sel,
   output logic [W-1:0]    y,
   output logic [SELW-1:0] y_chan,
   output logic            y_valid,
   input  logic            ready
);

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_RR     = 1'b1
   } mode_e;

   // Registered state
   logic [W-1:0]    y_q,       y_d;
   logic [SELW-1:0] y_chan_q,  y_chan_d;
   logic            y_valid_q, y_valid_d;
   logic [SELW-1:0] ptr_q,     ptr_d;     // last granted channel

   // Candidate selection
   logic            rr_found;
   logic [SELW-1:0] rr_idx;
   logic            man_found;
   logic            cand_found;
   logic [SELW-1:0] cand_idx;
   logic            load;
   logic [W-1:0]    cand_data;

   // --------------------------------------------------------------------------
   // Round-robin scan: visit ptr+1, ptr+2, ..., ptr (mod N) and take the first
   // requester. The loops only compare integers, so every select into `req`
   // uses a constant index and N need not be a power of two.
   // --------------------------------------------------------------------------
   // NOTE: every variable assigned in an always_comb gets a default at the top,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int k = 1; k <= N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!rr_found && req[i] && (i == ((int'(ptr_q) + k) % N))) begin
               rr_found = 1'b1;
               rr_idx   = SELW'(i);
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Manual select: the candidate exists only when sel names a real channel
   // that is requesting. An out-of-range sel matches no loop index, so it
   // yields no candidate.
   // --------------------------------------------------------------------------
   always_comb begin
      man_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if ((int'(sel) == i) && req[i]) begin
            man_found = 1'b1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Grant and output-register next state
   // --------------------------------------------------------------------------
   always_comb begin
      if (mode_e'(mode) == MODE_RR) begin
         cand_found = rr_found;
         cand_idx   = rr_idx;
      end else begin
         cand_found = man_found;
         cand_idx   = sel;
      end

      // The register may take a new beat when it is empty or its beat is
      // being accepted this cycle.
      load = !y_valid_q || ready;

      // grant is combinational from the inputs, so it is gated by rst_n
      // explicitly. This keeps it low while reset is held.
      grant = '0;
      if (rst_n && load && cand_found) begin
         for (int i = 0; i < N; i++) begin
            if (cand_idx == SELW'(i)) begin
               grant[i] = 1'b1;
            end
         end
      end

      // grant is one-hot or zero, so an OR of the masked channels is a plain
      // mux with no priority chain.
      cand_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            cand_data = cand_data | din[i*W +: W];
         end
      end

      y_d       = y_q;
      y_chan_d  = y_chan_q;
      y_valid_d = y_valid_q;
      ptr_d     = ptr_q;
      if (load) begin
         // With no candidate, data and channel keep their last values. Only
         // the valid flag drops.
         y_valid_d = |grant;
         if (|grant) begin
            y_d      = cand_data;
            y_chan_d = cand_idx;
            // The pointer follows grants in both modes, so round-robin
            // fairness carries on correctly after a manual period.
            ptr_d    = cand_idx;
         end
      end
   end

   // --------------------------------------------------------------------------
   // State registers. ptr resets to N-1, so the first round-robin scan starts
   // at channel 0.
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. All flops
   // then sample their d-values together on the edge, whatever the statement
   // order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q       <= '0;
         y_chan_q  <= '0;
         y_valid_q <= 1'b0;
         ptr_q     <= SELW'(N - 1);
      end else begin
         y_q       <= y_d;
         y_chan_q  <= y_chan_d;
         y_valid_q <= y_valid_d;
         ptr_q     <= ptr_d;
      end
   end

   assign y       = y_q;
   assign y_chan  = y_chan_q;
   assign y_valid = y_valid_q;

endmodule

// File: tb/tb_muxn_rr.sv
// -----------------------------------------------------------------------------
// tb_muxn_rr
//
// Directed bench for muxn_rr with N=4 and W=8. Each step drives the inputs
// just after a rising edge. At the next falling edge it compares grant with
// the grant the bench expects. For a grant it queues the beat it expects
// (data and channel taken from the bench's own din). After the following
// rising edge it pops that beat and compares it with y / y_chan / y_valid.
// -----------------------------------------------------------------------------
module tb_muxn_rr;

   localparam int W    = 8;
   localparam int N    = 4;
   localparam int SELW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*W-1:0]  din;
   logic [N-1:0]    req;
   logic [N-1:0]    grant;
   logic            mode;
   logic [SELW-1:0] sel;
   logic [W-1:0]    y;
   logic [SELW-1:0] y_chan;
   logic            y_valid;
   logic            ready;

   always #5 clk = ~clk;

   muxn_rr #(.W(W), .N(N), .SELW(SELW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (din),
      .req     (req),
      .grant   (grant),
      .mode    (mode),
      .sel     (sel),
      .y       (y),
      .y_chan  (y_chan),
      .y_valid (y_valid),
      .ready   (ready)
   );

   typedef struct packed {
      logic [W-1:0]    data;
      logic [SELW-1:0] chan;
   } beat_t;

   beat_t           exp_q[$];
   logic            yv_exp;
   logic [W-1:0]    y_exp;
   logic [SELW-1:0] ych_exp;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [SELW-1:0] idx_of(input logic [N-1:0] g);
      idx_of = '0;
      for (int i = 0; i < N; i++) begin
         if (g[i]) idx_of = SELW'(i);
      end
   endfunction

   // One clock cycle with the inputs as currently driven.
   task automatic cycle(input logic [N-1:0] exp_grant, input string tag);
      beat_t b;
      logic  load_m;
      @(negedge clk);
      check({tag, ".grant"}, 32'(grant), 32'(exp_grant));
      load_m = !yv_exp || ready;
      if (exp_grant != '0) begin
         b.chan = idx_of(exp_grant);
         b.data = din[int'(b.chan)*W +: W];
         exp_q.push_back(b);
      end
      @(posedge clk);
      #1;
      if (exp_grant != '0) begin
         b       = exp_q.pop_front();
         yv_exp  = 1'b1;
         y_exp   = b.data;
         ych_exp = b.chan;
      end else if (load_m) begin
         yv_exp = 1'b0;
      end
      check({tag, ".y_valid"}, 32'(y_valid), 32'(yv_exp));
      check({tag, ".y"},       32'(y),       32'(y_exp));
      check({tag, ".y_chan"},  32'(y_chan),  32'(ych_exp));
   endtask

   initial begin
      // Reset held with requests pending: grant must stay low.
      rst_n   = 1'b0;
      ready   = 1'b1;
      mode    = 1'b1;
      sel     = '0;
      req     = 4'b1111;
      din     = {8'h44, 8'h33, 8'h22, 8'h11};
      yv_exp  = 1'b0;
      y_exp   = '0;
      ych_exp = '0;
      #3;
      check("reset.grant",   32'(grant),   32'h0);
      check("reset.y",       32'(y),       32'h0);
      check("reset.y_chan",  32'(y_chan),  32'h0);
      check("reset.y_valid", 32'(y_valid), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Round-robin fairness from reset: channel 0 goes first.
      cycle(4'b0001, "rr_first");
      cycle(4'b0010, "rr_1");
      cycle(4'b0100, "rr_2");
      cycle(4'b1000, "rr_3");
      cycle(4'b0001, "rr_wrap");           // ptr = 0

      // Sparse requests with wrap-around.
      req = 4'b1001;
      cycle(4'b1000, "sparse_0");
      cycle(4'b0001, "sparse_1");
      cycle(4'b1000, "sparse_2");
      cycle(4'b0001, "sparse_3");          // ptr = 0

      // Manual mode on channel 2.
      mode = 1'b0;
      sel  = 2'd2;
      req  = 4'b0100;
      din  = {8'h44, 8'hA5, 8'h22, 8'h11};
      cycle(4'b0100, "man_0");
      cycle(4'b0100, "man_1");
      cycle(4'b0100, "man_2");
      req = 4'b0000;
      cycle(4'b0000, "man_drop");          // y_valid drops, y stays 0xA5
      check("man_drop.y_hold", 32'(y), 32'hA5);
      sel = 2'd3;
      req = 4'b0111;
      cycle(4'b0000, "man_sel3_idle");     // ptr = 2

      // Back-pressure.
      mode = 1'b1;
      req  = 4'b1111;
      din  = {8'h44, 8'h33, 8'h22, 8'h11};
      cycle(4'b1000, "bp_fill");           // y = 0x44, ptr = 3
      ready = 1'b0;
      cycle(4'b0000, "bp_stall0");
      cycle(4'b0000, "bp_stall1");
      cycle(4'b0000, "bp_stall2");
      ready = 1'b1;
      cycle(4'b0001, "bp_release");        // ptr = 0

      // Manual grants on channel 1, then switch to round-robin.
      mode = 1'b0;
      sel  = 2'd1;
      cycle(4'b0010, "sw_man0");
      cycle(4'b0010, "sw_man1");           // ptr = 1
      mode = 1'b1;
      cycle(4'b0100, "sw_rr0");
      cycle(4'b1000, "sw_rr1");

      // Reset asserted mid-stream, away from any clock edge.
      rst_n = 1'b0;
      #1;
      check("midrst.grant",   32'(grant),   32'h0);
      check("midrst.y",       32'(y),       32'h0);
      check("midrst.y_chan",  32'(y_chan),  32'h0);
      check("midrst.y_valid", 32'(y_valid), 32'h0);
      yv_exp  = 1'b0;
      y_exp   = '0;
      ych_exp = '0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle(4'b0001, "midrst_first");
      cycle(4'b0010, "midrst_next");

      check("scoreboard.empty", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muxn_rr.md
# muxn_rr

Parametrised N-channel, W-bit registered multiplexer: the successor to the team's combinational 2:1 mux. It adds a per-channel request/grant handshake, a registered output stage with valid/ready back-pressure, and two selection modes: manual select, and round-robin arbitration with a rotating priority pointer. It sits between multiple producer channels and a single downstream consumer, e.g. merging N sample streams onto one bus.

## Interface
- `W`, default 8: data width per channel.
- `N`, default 4: number of channels, N ≥ 2.
- `SELW`, default 2: select/channel-index width, ≥ ceil(log2(N)).

- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  N*W  channel data; channel i occupies bits [i*W +: W].
- `req`  in  N  per-channel request; channel i has data valid on din.
- `grant`  out  N  one-hot, combinational; channel i's data is taken this cycle.
- `mode`  in  1  0 = manual select, 1 = round-robin.
- `sel`  in  SELW  manual-mode channel index.
- `y`  out  W  registered output data.
- `y_chan`  out  SELW  channel index that produced y.
- `y_valid`  out  1  y/y_chan hold a valid beat.
- `ready`  in  1  downstream accepts the beat when y_valid && ready.

## Operation
- Internal state: output register (y, y_chan, y_valid), plus pointer `ptr` (SELW bits) holding the last granted channel.
- `load` = !y_valid || ready. The output register updates only when load = 1; otherwise y, y_chan and y_valid hold, and grant = 0.
- Candidate selection, evaluated combinationally each cycle:
  - mode = 0: the candidate is sel if sel < N and req[sel] = 1; otherwise there is no candidate. sel ≥ N is legal and yields no candidate.
  - mode = 1: the candidate is the first i with req[i] = 1, scanning ptr+1, ptr+2, …, ptr in that order (mod N). The last-granted channel therefore has lowest priority.
- On load with candidate c:
  - grant[c] = 1 in the same cycle.
  - Next edge: y ← din[c], y_chan ← c, y_valid ← 1, ptr ← c.
- On load with no candidate: grant = 0, y_valid ← 0, y and y_chan hold their previous values, ptr holds.
- ptr updates on every grant in both modes, so round-robin fairness continues correctly after a manual-to-RR switch.
- Producers must hold din[i] and req[i] until they see grant[i] = 1. grant is never asserted to a channel whose req = 0.
- mode and sel are sampled every cycle. A change takes effect at the next load cycle; there is no drain or flush.
- At most one grant bit is set in any cycle.

## Timing
- Reset (async assert, any time, including mid-transfer): y = 0, y_chan = 0, y_valid = 0, ptr = N-1, so channel 0 has top priority first. grant = 0 while rst_n = 0.
- Reset deassertion is synchronised externally. The first grant can occur in the first cycle after rst_n rises.
- Latency: grant in cycle t gives y_valid = 1 with the data in cycle t+1.
- Throughput: with ready held at 1, one beat per cycle.
- Back-pressure: when y_valid = 1 and ready = 0, grant = 0 and the output holds stable until ready = 1. In the cycle ready rises, the next grant and load occur (beat accept and refill in the same cycle).
- Wrap-around: with ptr = N-1, the scan starts at channel 0.
- Single requester: that channel is granted every load cycle, back-to-back.
- All req = 0 with ready = 1: y_valid drops after the current beat is accepted.

## Test plan
All scenarios use N=4, W=8.
1. Reset: assert rst_n = 0 mid-stream with y_valid = 1 → y = 0x00, y_valid = 0, grant = 0 immediately. After release, req = 4'b1111, mode = 1 → first grant = 4'b0001.
2. Round-robin fairness: req = 4'b1111, ready = 1, din = {0x44,0x33,0x22,0x11} → y = 0x11, 0x22, 0x33, 0x44, 0x11… on consecutive cycles, with y_chan = 0, 1, 2, 3, 0.
3. Sparse and wrap: mode = 1, req = 4'b1001 → grants alternate 0001, 1000, 0001, …; y_chan alternates 0, 3.
4. Manual mode: mode = 0, sel = 2, req = 4'b0100, din[2] = 0xA5 → y = 0xA5, y_chan = 2 each cycle. Then req[2] = 0 → y_valid = 0 next cycle while y stays 0xA5. sel = 3 with req[3] = 0 → no grant.
5. Back-pressure: y_valid = 1, ready = 0 for 3 cycles with req = 4'b1111 → grant = 0 and y stable throughout. Raise ready → grant issues in the same cycle and y updates on the next edge.
6. Mode switch: manual grants on sel = 1 for 2 beats, then switch mode = 1 with req = 4'b1111 → next grant = channel 2, since ptr = 1.
